// File: rtl/calendar_date.sv
// Calendar date keeper: BCD month/day plus binary day-of-year, advanced by a
// prescaled day_tick and loadable with range-checked BCD values.
module calendar_date #(
    parameter int TICKS_PER_DAY = 1
) (
    input  logic       ADC_CLK_10,
    input  logic       RST,
    input  logic       day_tick,
    input  logic       leap,
    input  logic       load,
    input  logic [7:0] set_month,
    input  logic [7:0] set_day,
    output logic [7:0] month_bcd,
    output logic [7:0] day_bcd,
    output logic [8:0] doy,
    output logic       year_wrap,
    output logic       load_ack,
    output logic       load_err
);

    localparam logic [7:0] TPD_LAST = 8'(TICKS_PER_DAY - 1);

    logic [7:0] month_q, month_d;
    logic [7:0] day_q, day_d;
    logic [8:0] doy_q, doy_d;
    logic [7:0] presc_q, presc_d;
    logic       year_wrap_q, year_wrap_d;
    logic       load_ack_q, load_ack_d;
    logic       load_err_q, load_err_d;

    function automatic logic [4:0] month_len(input logic [7:0] m, input logic lp);
        case (m)
            8'h01, 8'h03, 8'h05, 8'h07, 8'h08, 8'h10, 8'h12: month_len = 5'd31;
            8'h04, 8'h06, 8'h09, 8'h11:                      month_len = 5'd30;
            8'h02:   month_len = lp ? 5'd29 : 5'd28;
            default: month_len = 5'd31;
        endcase
    endfunction

    // Days in all months before m; February contributes 29 only in a leap year.
    function automatic logic [8:0] days_before(input logic [7:0] m, input logic lp);
        logic [8:0] base;
        case (m)
            8'h01:   base = 9'd0;
            8'h02:   base = 9'd31;
            8'h03:   base = 9'd59;
            8'h04:   base = 9'd90;
            8'h05:   base = 9'd120;
            8'h06:   base = 9'd151;
            8'h07:   base = 9'd181;
            8'h08:   base = 9'd212;
            8'h09:   base = 9'd243;
            8'h10:   base = 9'd273;
            8'h11:   base = 9'd304;
            8'h12:   base = 9'd334;
            default: base = 9'd0;
        endcase
        days_before = base + {8'd0, (lp && (m != 8'h01) && (m != 8'h02))};
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] >= 4'd9) begin
            bcd_inc = {v[7:4] + 4'd1, 4'd0};
        end else begin
            bcd_inc = {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] v);
        bcd_to_bin = ({3'd0, v[7:4]} * 7'd10) + {3'd0, v[3:0]};
    endfunction

    function automatic logic bcd_digits_ok(input logic [7:0] v);
        bcd_digits_ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    logic month_ok_s;
    logic day_ok_s;
    logic tick_s;
    logic advance_s;

    // Next-state: load beats tick; a tick under a load is simply dropped.
    always_comb begin
        month_d     = month_q;
        day_d       = day_q;
        doy_d       = doy_q;
        presc_d     = presc_q;
        year_wrap_d = 1'b0;
        load_ack_d  = 1'b0;
        load_err_d  = 1'b0;
        month_ok_s  = bcd_digits_ok(set_month) && (set_month != 8'h00) && (set_month <= 8'h12);
        day_ok_s    = bcd_digits_ok(set_day) && (set_day != 8'h00) &&
                      (bcd_to_bin(set_day) <= {2'd0, month_len(set_month, leap)});
        tick_s      = day_tick && !load;
        advance_s   = tick_s && (presc_q >= TPD_LAST);

        if (load) begin
            if (month_ok_s && day_ok_s) begin
                month_d    = set_month;
                day_d      = set_day;
                doy_d      = days_before(set_month, leap) + {2'd0, bcd_to_bin(set_day)};
                presc_d    = 8'd0;
                load_ack_d = 1'b1;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (tick_s) begin
            presc_d = advance_s ? 8'd0 : presc_q + 8'd1;
            // >= lets a stored Feb 29 roll to Mar 01 after leap drops.
            if (!advance_s) begin
                day_d = day_q;
            end else if (bcd_to_bin(day_q) < {2'd0, month_len(month_q, leap)}) begin
                day_d = bcd_inc(day_q);
                doy_d = doy_q + 9'd1;
            end else if (month_q == 8'h12) begin
                day_d       = 8'h01;
                month_d     = 8'h01;
                doy_d       = 9'd1;
                year_wrap_d = 1'b1;
            end else begin
                day_d   = 8'h01;
                month_d = bcd_inc(month_q);
                doy_d   = doy_q + 9'd1;
            end
        end else begin
            presc_d = presc_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge ADC_CLK_10 or posedge RST) begin
        if (RST) begin
            month_q     <= 8'h01;
            day_q       <= 8'h01;
            doy_q       <= 9'd1;
            presc_q     <= 8'd0;
            year_wrap_q <= 1'b0;
            load_ack_q  <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            month_q     <= month_d;
            day_q       <= day_d;
            doy_q       <= doy_d;
            presc_q     <= presc_d;
            year_wrap_q <= year_wrap_d;
            load_ack_q  <= load_ack_d;
            load_err_q  <= load_err_d;
        end
    end

    assign month_bcd = month_q;
    assign day_bcd   = day_q;
    assign doy       = doy_q;
    assign year_wrap = year_wrap_q;
    assign load_ack  = load_ack_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_calendar_date.sv
// Directed bench for calendar_date: one instance with TICKS_PER_DAY=1, one with 3.
module tb_calendar_date;

    logic       clk;
    logic       rst;
    logic       day_tick;
    logic       leap;
    logic       load;
    logic [7:0] set_month;
    logic [7:0] set_day;

    logic [7:0] m1, d1, m3, d3;
    logic [8:0] y1, y3;
    logic       w1, a1, e1, w3, a3, e3;

    int n_cmp;
    int n_mis;

    calendar_date #(.TICKS_PER_DAY(1)) u1 (
        .ADC_CLK_10(clk), .RST(rst), .day_tick(day_tick), .leap(leap), .load(load),
        .set_month(set_month), .set_day(set_day),
        .month_bcd(m1), .day_bcd(d1), .doy(y1),
        .year_wrap(w1), .load_ack(a1), .load_err(e1)
    );

    calendar_date #(.TICKS_PER_DAY(3)) u3 (
        .ADC_CLK_10(clk), .RST(rst), .day_tick(day_tick), .leap(leap), .load(load),
        .set_month(set_month), .set_day(set_day),
        .month_bcd(m3), .day_bcd(d3), .doy(y3),
        .year_wrap(w3), .load_ack(a3), .load_err(e3)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_mis = n_mis + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic [7:0] m, input logic [7:0] d, input logic [8:0] y);
        check({tag, "/month"}, {24'd0, m1}, {24'd0, m});
        check({tag, "/day"},   {24'd0, d1}, {24'd0, d});
        check({tag, "/doy"},   {23'd0, y1}, {23'd0, y});
    endtask

    task automatic chk3(input string tag, input logic [7:0] m, input logic [7:0] d, input logic [8:0] y);
        check({tag, "/month3"}, {24'd0, m3}, {24'd0, m});
        check({tag, "/day3"},   {24'd0, d3}, {24'd0, d});
        check({tag, "/doy3"},   {23'd0, y3}, {23'd0, y});
    endtask

    task automatic do_tick();
        day_tick = 1'b1;
        @(negedge clk);
        day_tick = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] m, input logic [7:0] d);
        load      = 1'b1;
        set_month = m;
        set_day   = d;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_mis     = 0;
        rst       = 1'b1;
        day_tick  = 1'b0;
        leap      = 1'b0;
        load      = 1'b0;
        set_month = 8'h00;
        set_day   = 8'h00;

        #10;
        chk1("reset", 8'h01, 8'h01, 9'd1);
        check("reset/wrap", {31'd0, w1}, 32'd0);
        check("reset/ack",  {31'd0, a1}, 32'd0);
        check("reset/err",  {31'd0, e1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 31 ticks from Jan 01 land on Feb 01
        for (int i = 1; i <= 31; i++) begin
            do_tick();
            if (i == 9) chk1("jan10", 8'h01, 8'h10, 9'd10);
        end
        chk1("feb01", 8'h02, 8'h01, 9'd32);

        leap = 1'b1;
        do_load(8'h02, 8'h28);
        check("ld0228/ack", {31'd0, a1}, 32'd1);
        chk1("ld0228L", 8'h02, 8'h28, 9'd59);
        do_tick();
        check("ack_pulse", {31'd0, a1}, 32'd0);
        chk1("feb29L", 8'h02, 8'h29, 9'd60);
        do_tick();
        chk1("mar01L", 8'h03, 8'h01, 9'd61);

        leap = 1'b0;
        do_load(8'h02, 8'h28);
        do_tick();
        chk1("mar01", 8'h03, 8'h01, 9'd60);

        do_load(8'h12, 8'h31);
        chk1("ld1231", 8'h12, 8'h31, 9'd365);
        do_tick();
        chk1("wrap", 8'h01, 8'h01, 9'd1);
        check("wrap/pulse", {31'd0, w1}, 32'd1);
        @(negedge clk);
        check("wrap/one", {31'd0, w1}, 32'd0);

        do_load(8'h13, 8'h01);
        check("ld1301/err", {31'd0, e1}, 32'd1);
        check("ld1301/ack", {31'd0, a1}, 32'd0);
        chk1("ld1301", 8'h01, 8'h01, 9'd1);
        do_load(8'h04, 8'h31);
        check("ld0431/err", {31'd0, e1}, 32'd1);
        chk1("ld0431", 8'h01, 8'h01, 9'd1);
        do_load(8'h02, 8'h1A);
        check("ld021A/err", {31'd0, e1}, 32'd1);
        do_load(8'h02, 8'h29);
        check("ld0229nl/err", {31'd0, e1}, 32'd1);
        chk1("ld0229nl", 8'h01, 8'h01, 9'd1);
        do_load(8'h09, 8'h30);
        check("ld0930/ack", {31'd0, a1}, 32'd1);
        check("ld0930/err", {31'd0, e1}, 32'd0);
        chk1("ld0930", 8'h09, 8'h30, 9'd273);
        do_tick();
        chk1("oct01", 8'h10, 8'h01, 9'd274);

        // Leap drops while sitting on Feb 29
        leap = 1'b1;
        do_load(8'h02, 8'h29);
        chk1("ld0229L", 8'h02, 8'h29, 9'd60);
        leap = 1'b0;
        do_tick();
        chk1("leapdrop", 8'h03, 8'h01, 9'd61);

        // Divided instance: load with a simultaneous tick
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        day_tick = 1'b1;
        do_load(8'h05, 8'h15);
        day_tick = 1'b0;
        check("ld3/ack", {31'd0, a3}, 32'd1);
        chk3("ld3", 8'h05, 8'h15, 9'd135);
        do_tick();
        do_tick();
        chk3("t3_2", 8'h05, 8'h15, 9'd135);
        do_tick();
        chk3("t3_3", 8'h05, 8'h16, 9'd136);
        do_tick();
        chk3("t3_4", 8'h05, 8'h16, 9'd136);

        // Asynchronous reset between edges, mid-count
        #20;
        rst = 1'b1;
        #1;
        chk3("arst", 8'h01, 8'h01, 9'd1);
        chk1("arst1", 8'h01, 8'h01, 9'd1);
        check("arst/ack3", {31'd0, a3}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_tick();
        do_tick();
        chk3("post2", 8'h01, 8'h01, 9'd1);
        do_tick();
        chk3("post3", 8'h01, 8'h02, 9'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/calendar_date.md
CALENDAR_DATE -- requirements
Module: calendar_date

Interface
REQ-001 Parameter TICKS_PER_DAY, default 1, meaning: number of accepted day_tick pulses per one-day advance (legal range 1-255).
REQ-002 ADC_CLK_10  input  1  10 MHz system clock; all state SHALL update on its rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 day_tick  input  1  one-cycle advance pulse from the upstream seconds/tick counter.
REQ-005 leap  input  1  1 = current year is a leap year (Feb has 29 days); sampled only when an advance or a load is evaluated.
REQ-006 load  input  1  one-cycle strobe requesting that set_month/set_day be loaded.
REQ-007 set_month  input  8  BCD month to load (two digits, [7:4] tens, [3:0] units).
REQ-008 set_day  input  8  BCD day to load.
REQ-009 month_bcd  output  8  current month, BCD 01-12, registered.
REQ-010 day_bcd  output  8  current day, BCD 01-31, registered.
REQ-011 doy  output  9  current day-of-year, binary 1-366, registered.
REQ-012 year_wrap  output  1  one-cycle pulse on Dec 31 -> Jan 01 rollover.
REQ-013 load_ack  output  1  one-cycle pulse: load accepted.
REQ-014 load_err  output  1  one-cycle pulse: load rejected.

Function
REQ-015 Prescaler: 8-bit counter SHALL count accepted day_tick pulses; on the pulse bringing it to TICKS_PER_DAY it SHALL clear to 0 and issue an internal advance; with TICKS_PER_DAY=1 every day_tick is an advance.
REQ-016 Latency: outputs SHALL reflect an advance on the clock edge that samples the qualifying day_tick (registered outputs valid the following cycle); no other delay.
REQ-017 Month length: 31 for months 01,03,05,07,08,10,12; 30 for 04,06,09,11; 02 is 29 if leap=1 else 28.
REQ-018 Advance, day < month length: day_bcd SHALL increment in BCD (units 9 -> 0 with tens +1), doy +1.
REQ-019 Advance, day = month length, month < 12: day_bcd -> 01, month_bcd increments in BCD (09 -> 10), doy +1.
REQ-020 Advance on Dec 31: month_bcd -> 01, day_bcd -> 01, doy -> 1, year_wrap = 1 for exactly that one cycle.
REQ-021 Load validity: every BCD digit <= 9, month 01-12, day 01 to month length (using leap that cycle); otherwise invalid.
REQ-022 Valid load: month_bcd/day_bcd SHALL take set values, doy SHALL be (cumulative days before month, Feb counted per leap) + day, prescaler SHALL clear, load_ack = 1 for one cycle.
REQ-023 Invalid load: date, doy and prescaler unchanged, load_err = 1 for one cycle.
REQ-024 Simultaneous load and day_tick: load SHALL take priority; that day_tick is discarded (not counted by the prescaler).
REQ-025 leap changing mid-year SHALL NOT retroactively alter the stored date; if leap falls to 0 while date is Feb 29, the next advance SHALL go to Mar 01.
REQ-026 year_wrap, load_ack, load_err SHALL never be high in the same cycle as each other, and SHALL never be high for more than one cycle per event.
REQ-027 No illegal state (day 00, month 00/13+, non-BCD digit) SHALL be reachable from reset via any input sequence.

Reset
REQ-028 While RST = 1, asynchronously and independent of the clock: month_bcd = 8'h01, day_bcd = 8'h01, doy = 1, prescaler = 0, year_wrap = load_ack = load_err = 0.
REQ-029 RST asserted mid-operation (including the cycle of a load or day_tick) SHALL override all other inputs; the first advance after release SHALL need a full TICKS_PER_DAY pulses.

Verification
REQ-030 Reset, then 31 day_tick (TICKS_PER_DAY=1) -> month_bcd 02, day_bcd 01, doy 32.
REQ-031 Load 02/28 leap=1, 1 tick -> 02/29 doy 60; 1 more tick -> 03/01 doy 61; repeat with leap=0 from 02/28 -> 03/01 doy 60.
REQ-032 Load 12/31 leap=0, 1 tick -> 01/01, doy 1, year_wrap high exactly one cycle.
REQ-033 Load 13/01, then 04/31, then 02/1A -> load_err pulse each, date unchanged; load 09/30 -> load_ack, then 1 tick -> 10/01 doy 274.
REQ-034 TICKS_PER_DAY=3: load and day_tick same cycle -> load wins; then 2 ticks no change, 3rd tick advances one day.
REQ-035 Assert RST asynchronously between clock edges mid-count -> outputs 01/01 doy 1 immediately, pulses low.
